// File: rtl/alu_sliced.sv
// Multi-cycle ALU that processes WIDTH-bit operands SLICE bits per clock, with valid/ready handshakes.
// Optional status flags are built only when ALU_SLICED_FLAGS_EN is defined; otherwise the flag ports read 0.
module alu_sliced #(
    parameter int WIDTH = 128,
    parameter int SLICE = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cin,
    input  logic [2:0]       opsel,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             c_flag,
    output logic             z_flag,
    output logic             o_flag,
    output logic             s_flag
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg, state_next;
    logic [KW-1:0]    k_reg, k_next;
    logic [WIDTH-1:0] a_reg, a_next, b_reg, b_next;
    logic [2:0]       opsel_reg, opsel_next;
    logic             mode_reg, mode_next;
    logic             carry_reg, carry_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             cout_reg, cout_next;

    logic [SLICE-1:0] a_sl, b_sl, ea, eb, lres, slice_res;
    logic [SLICE:0]   sum;
    logic             slice_cout, eff_cin, accept, last, finish;

    assign accept = (state_reg == IDLE) && in_valid;
    assign last   = (k_reg == KW'(NSLICE - 1));
    assign finish = (state_reg == BUSY) && last;

    // Operation carry-in, chosen at acceptance and then replaced by each slice's carry-out.
    always_comb begin
        eff_cin = 1'b0;
        case (opsel)
            3'b001, 3'b011: eff_cin = cin;
            3'b010, 3'b100: eff_cin = 1'b1;
            default:        eff_cin = 1'b0;
        endcase
    end

    // One slice of the datapath; pass ops are folded into the adder with a zeroed operand.
    always_comb begin
        a_sl = a_reg[k_reg*SLICE +: SLICE];
        b_sl = b_reg[k_reg*SLICE +: SLICE];
        ea   = a_sl;
        eb   = b_sl;
        case (opsel_reg)
            3'b010, 3'b011: eb = ~b_sl;
            3'b100, 3'b110: eb = '0;
            3'b101:         eb = '1;
            3'b111:         ea = '0;
            default:        eb = b_sl;
        endcase
        sum = {1'b0, ea} + {1'b0, eb} + {{SLICE{1'b0}}, carry_reg};
        case (opsel_reg)
            3'b000:  lres = a_sl & b_sl;
            3'b001:  lres = a_sl | b_sl;
            3'b010:  lres = a_sl ^ b_sl;
            3'b011:  lres = ~a_sl;
            3'b100:  lres = ~(a_sl & b_sl);
            3'b101:  lres = ~(a_sl | b_sl);
            3'b110:  lres = ~(a_sl ^ b_sl);
            default: lres = b_sl;
        endcase
        slice_res  = mode_reg ? lres : sum[SLICE-1:0];
        slice_cout = mode_reg ? 1'b0 : sum[SLICE];
    end

    always_comb begin
        state_next  = state_reg;
        k_next      = k_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        opsel_next  = opsel_reg;
        mode_next   = mode_reg;
        carry_next  = carry_reg;
        acc_next    = acc_reg;
        result_next = result_reg;
        cout_next   = cout_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next = BUSY;
                    k_next     = '0;
                    a_next     = op1;
                    b_next     = op2;
                    opsel_next = opsel;
                    mode_next  = mode;
                    carry_next = eff_cin;
                    acc_next   = '0;
                end
            end
            BUSY: begin
                acc_next[k_reg*SLICE +: SLICE] = slice_res;
                carry_next = slice_cout;
                if (last) begin
                    state_next  = DONE;
                    result_next = acc_next;
                    cout_next   = slice_cout;
                end else begin
                    k_next = k_reg + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            k_reg      <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            opsel_reg  <= '0;
            mode_reg   <= 1'b0;
            carry_reg  <= 1'b0;
            acc_reg    <= '0;
            result_reg <= '0;
            cout_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            k_reg      <= k_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            opsel_reg  <= opsel_next;
            mode_reg   <= mode_next;
            carry_reg  <= carry_next;
            acc_reg    <= acc_next;
            result_reg <= result_next;
            cout_reg   <= cout_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign cout      = cout_reg;

`ifdef ALU_SLICED_FLAGS_EN
    logic zacc_reg, zacc_next;
    logic z_reg, z_next, o_reg, o_next, s_reg, s_next;

    // Zero flag accumulates slice by slice; overflow uses the MSB slice's effective operands.
    always_comb begin
        zacc_next = zacc_reg;
        z_next    = z_reg;
        o_next    = o_reg;
        s_next    = s_reg;
        if (accept) zacc_next = 1'b1;
        if (state_reg == BUSY) zacc_next = zacc_reg & ~(|slice_res);
        if (finish) begin
            z_next = zacc_next;
            s_next = slice_res[SLICE-1];
            o_next = ~mode_reg && (opsel_reg <= 3'b101) &&
                     (ea[SLICE-1] == eb[SLICE-1]) && (slice_res[SLICE-1] != ea[SLICE-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zacc_reg <= 1'b0;
            z_reg    <= 1'b0;
            o_reg    <= 1'b0;
            s_reg    <= 1'b0;
        end else begin
            zacc_reg <= zacc_next;
            z_reg    <= z_next;
            o_reg    <= o_next;
            s_reg    <= s_next;
        end
    end

    assign c_flag = cout_reg;
    assign z_flag = z_reg;
    assign o_flag = o_reg;
    assign s_flag = s_reg;
`else
    assign c_flag = 1'b0;
    assign z_flag = 1'b0;
    assign o_flag = 1'b0;
    assign s_flag = 1'b0;
`endif

endmodule
